// File: rtl/image_pkg.sv
// image_pkg: definitions shared by read_data, write_data and their benches.
//   - default image geometry
//   - read-side FSM state encoding
//   - bit offsets of the six 8-bit colour fields within a 48-bit RAM word
//     (even pixel in the low 24 bits, odd pixel in the high 24 bits)
//   - small helpers for field extraction and counter sizing
package image_pkg;

  localparam int unsigned IMAGE_WIDTH_DEF  = 768;
  localparam int unsigned IMAGE_HEIGHT_DEF = 512;
  localparam int unsigned WORD_WIDTH       = 48;

  localparam int unsigned R_EVEN_LSB = 16;
  localparam int unsigned G_EVEN_LSB = 8;
  localparam int unsigned B_EVEN_LSB = 0;
  localparam int unsigned R_ODD_LSB  = 40;
  localparam int unsigned G_ODD_LSB  = 32;
  localparam int unsigned B_ODD_LSB  = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_HGAP,
    S_LINE,
    S_FLUSH,
    S_DONE
  } rd_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t even_pixel(input logic [WORD_WIDTH-1:0] w);
    rgb_t p;
    p.r = w[R_EVEN_LSB +: 8];
    p.g = w[G_EVEN_LSB +: 8];
    p.b = w[B_EVEN_LSB +: 8];
    return p;
  endfunction

  function automatic rgb_t odd_pixel(input logic [WORD_WIDTH-1:0] w);
    rgb_t p;
    p.r = w[R_ODD_LSB +: 8];
    p.g = w[G_ODD_LSB +: 8];
    p.b = w[B_ODD_LSB +: 8];
    return p;
  endfunction

  // Width able to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/read_data_if.sv
// read_data_if: frame-buffer RAM read bus plus the outgoing pixel stream.
//   master (read_data side):
//     mem_Addr, mem_Read_Enable  out  RAM word address and read strobe
//     mem_Data                   in   48-bit RAM word, valid 1 cycle after strobe
//     vertical_Pulse             out  pre-frame sync period
//     horizontal_Pulse           out  data outputs carry a valid pixel pair
//     data_{Red,Green,Blue}_{Even,Odd}  out  8-bit pixel components
//   slave: the mirror image (RAM model / downstream consumer).
interface read_data_if #(
  parameter int unsigned ADDR_WIDTH = 18
);
  logic [ADDR_WIDTH-1:0] mem_Addr;
  logic                  mem_Read_Enable;
  logic [47:0]           mem_Data;
  logic                  vertical_Pulse;
  logic                  horizontal_Pulse;
  logic [7:0]            data_Red_Even;
  logic [7:0]            data_Green_Even;
  logic [7:0]            data_Blue_Even;
  logic [7:0]            data_Red_Odd;
  logic [7:0]            data_Green_Odd;
  logic [7:0]            data_Blue_Odd;

  modport master (
    output mem_Addr, mem_Read_Enable,
    input  mem_Data,
    output vertical_Pulse, horizontal_Pulse,
    output data_Red_Even, data_Green_Even, data_Blue_Even,
    output data_Red_Odd, data_Green_Odd, data_Blue_Odd
  );

  modport slave (
    input  mem_Addr, mem_Read_Enable,
    output mem_Data,
    input  vertical_Pulse, horizontal_Pulse,
    input  data_Red_Even, data_Green_Even, data_Blue_Even,
    input  data_Red_Odd, data_Green_Odd, data_Blue_Odd
  );
endinterface

// File: rtl/read_timing_counter.sv
// read_timing_counter: loadable down-counter with a zero flag, used to time
// the VSYNC and HGAP periods of read_data.
//   clk, reset  in   clock, synchronous active-high reset
//   i_load      in   load i_value (has priority over i_dec)
//   i_value     in   value to load
//   i_dec       in   decrement by one; saturates at zero
//   o_zero      out  count is zero
module read_timing_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);
endmodule

// File: rtl/read_data.sv
// read_data: frame source for the threshold pipeline. On a start pulse in
// IDLE it holds vertical_Pulse for VSYNC_CYCLES, then for every row waits
// HSYNC_GAP idle cycles and reads IMAGE_WIDTH/2 consecutive RAM words, each
// holding an even/odd pixel pair. Pairs appear on the data outputs with
// horizontal_Pulse one cycle after their read strobe.
//   clk, reset      in   clock, synchronous active-high reset
//   start           in   one-cycle frame request, honoured only in IDLE
//   bus             master modport of read_data_if (RAM bus + pixel stream)
//   sig_Read_Done   out  one-cycle pulse at the end of the frame
//   busy            out  high in any state except IDLE
module read_data
  import image_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
  parameter int unsigned IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
  parameter int unsigned VSYNC_CYCLES = 100,
  parameter int unsigned HSYNC_GAP    = 160,
  parameter int unsigned ADDR_WIDTH   = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  read_data_if.master   bus,
  output logic          sig_Read_Done,
  output logic          busy
);
  localparam int unsigned HALF  = IMAGE_WIDTH / 2;
  localparam int unsigned COL_W = clog2_min1(HALF);
  localparam int unsigned ROW_W = clog2_min1(IMAGE_HEIGHT);
  localparam int unsigned CNT_W = clog2_min1(max_u(VSYNC_CYCLES, HSYNC_GAP));

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(HALF - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [CNT_W-1:0] VS_LOAD  = CNT_W'(VSYNC_CYCLES - 1);
  localparam logic [CNT_W-1:0] HG_LOAD  = CNT_W'(HSYNC_GAP - 1);

  rd_state_t             r_state;
  logic [ROW_W-1:0]      r_row;
  logic [COL_W-1:0]      r_col;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd_en;
  logic                  r_vpulse;
  logic                  r_done;
  logic                  r_busy;

  logic                  r_valid;
  rgb_t                  r_hold_even;
  rgb_t                  r_hold_odd;

  logic                  w_cnt_load;
  logic [CNT_W-1:0]      w_cnt_value;
  logic                  w_cnt_dec;
  logic                  w_cnt_zero;
  logic                  w_col_last;
  logic                  w_row_last;
  rgb_t                  w_even;
  rgb_t                  w_odd;
  rgb_t                  w_out_even;
  rgb_t                  w_out_odd;

  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  // The counter is loaded on the transition into a timed state, so it
  // reaches zero in that state's last cycle.
  always_comb begin
    w_cnt_load  = 1'b0;
    w_cnt_value = HG_LOAD;
    w_cnt_dec   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt_load  = 1'b1;
          w_cnt_value = VS_LOAD;
        end
      end
      S_VSYNC: begin
        if (w_cnt_zero) w_cnt_load = 1'b1;
        else            w_cnt_dec  = 1'b1;
      end
      S_HGAP: w_cnt_dec = 1'b1;
      S_LINE: begin
        if (w_col_last && !w_row_last) w_cnt_load = 1'b1;
      end
      default: ;
    endcase
  end

  read_timing_counter #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_cnt_load),
    .i_value (w_cnt_value),
    .i_dec   (w_cnt_dec),
    .o_zero  (w_cnt_zero)
  );

  // Outputs are set on the transition into a state so they are registered
  // yet line up exactly with the state they describe. Rows are contiguous in
  // RAM, so a running address equals row*(IMAGE_WIDTH/2)+col.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_addr   <= '0;
      r_rd_en  <= 1'b0;
      r_vpulse <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_VSYNC;
            r_vpulse <= 1'b1;
            r_busy   <= 1'b1;
            r_row    <= '0;
            r_col    <= '0;
            r_addr   <= '0;
          end
        end
        S_VSYNC: begin
          if (w_cnt_zero) begin
            r_state  <= S_HGAP;
            r_vpulse <= 1'b0;
          end
        end
        S_HGAP: begin
          if (w_cnt_zero) begin
            r_state <= S_LINE;
            r_rd_en <= 1'b1;
            r_col   <= '0;
          end
        end
        S_LINE: begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
          r_col  <= r_col + COL_W'(1);
          if (w_col_last) begin
            r_rd_en <= 1'b0;
            if (w_row_last) begin
              r_state <= S_FLUSH;
            end else begin
              r_state <= S_HGAP;
              r_row   <= r_row + ROW_W'(1);
            end
          end
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_rd_en  <= 1'b0;
          r_vpulse <= 1'b0;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  // r_valid marks the cycle in which the RAM word for a strobe is on
  // mem_Data. That word is shown directly while valid and captured at the
  // end of the cycle, so the outputs keep showing it once valid drops.
  // Clearing r_valid on reset drops any read still in flight.
  assign w_even = even_pixel(bus.mem_Data);
  assign w_odd  = odd_pixel(bus.mem_Data);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_hold_even <= '0;
      r_hold_odd  <= '0;
    end else begin
      r_valid <= r_rd_en;
      if (r_valid) begin
        r_hold_even <= w_even;
        r_hold_odd  <= w_odd;
      end
    end
  end

  assign w_out_even = r_valid ? w_even : r_hold_even;
  assign w_out_odd  = r_valid ? w_odd  : r_hold_odd;

  assign bus.mem_Addr         = r_addr;
  assign bus.mem_Read_Enable  = r_rd_en;
  assign bus.vertical_Pulse   = r_vpulse;
  assign bus.horizontal_Pulse = r_valid;
  assign bus.data_Red_Even    = w_out_even.r;
  assign bus.data_Green_Even  = w_out_even.g;
  assign bus.data_Blue_Even   = w_out_even.b;
  assign bus.data_Red_Odd     = w_out_odd.r;
  assign bus.data_Green_Odd   = w_out_odd.g;
  assign bus.data_Blue_Odd    = w_out_odd.b;
  assign sig_Read_Done        = r_done;
  assign busy                 = r_busy;
endmodule
